// File: rtl/ir_dec_stage.sv
// RV32 decode stage: elastic valid/ready input, small instruction buffer,
// combinational RV32I/M decoder and a registered output bundle.
module ir_dec_stage #(
  parameter int FIFO_DEPTH = 2,
  parameter int PC_WIDTH   = 32,
  parameter bit EN_M       = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_instr,
  input  logic [PC_WIDTH-1:0] in_pc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [PC_WIDTH-1:0] out_pc,
  output logic [4:0]          out_rs1,
  output logic [4:0]          out_rs2,
  output logic [4:0]          out_rd,
  output logic [2:0]          out_func3,
  output logic [31:0]         out_imm,
  output logic [1:0]          out_alu_src_sel,
  output logic [12:0]         out_cs,
  output logic                out_illegal
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_kind_t;

  logic [31:0]         buf_instr [FIFO_DEPTH];
  logic [PC_WIDTH-1:0] buf_pc    [FIFO_DEPTH];
  logic [PTR_W-1:0]    head_reg, tail_reg;
  logic [CNT_W-1:0]    count_reg;
  logic                out_valid_reg;

  logic accept, out_load, buf_empty, bypass, enq, deq, load_valid;
  logic [31:0]         dec_instr;
  logic [PC_WIDTH-1:0] dec_pc;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign in_ready   = !rst && (count_reg < CNT_W'(FIFO_DEPTH));
  assign out_valid  = out_valid_reg;
  assign accept     = in_valid && in_ready;
  assign out_load   = !out_valid_reg || out_ready;
  assign buf_empty  = (count_reg == '0);
  assign bypass     = buf_empty && out_load && accept;
  assign enq        = accept && !bypass && !flush;
  assign deq        = out_load && !buf_empty;
  assign load_valid = deq || bypass;
  // With an empty buffer the decoder looks straight at the fetch word.
  assign dec_instr  = buf_empty ? in_instr : buf_instr[head_reg];
  assign dec_pc     = buf_empty ? in_pc    : buf_pc[head_reg];

  // ---------------- decoder ----------------
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        legal, c_s, c_l, c_w, c_b, c_j, c_a, c_m, c_sign, c_sext, c_ign, c_sys;
  logic [1:0]  c_dw;
  imm_kind_t   imm_kind;
  logic [12:0] d_cs;
  logic [31:0] d_imm;
  logic [1:0]  d_sel;
  logic        d_ill;

  assign opc = dec_instr[6:0];
  assign f3  = dec_instr[14:12];
  assign f7  = dec_instr[31:25];

  always_comb begin
    legal = 1'b0; c_s = 1'b0; c_l = 1'b0; c_w = 1'b0; c_b = 1'b0; c_j = 1'b0;
    c_a = 1'b0; c_m = 1'b0; c_sign = 1'b0; c_sext = 1'b0; c_ign = 1'b0;
    c_sys = 1'b0; c_dw = 2'b00; imm_kind = IMM_NONE;
    case (opc)
      7'b0110111: begin legal = 1'b1; c_w = 1'b1; c_ign = 1'b1; imm_kind = IMM_U; end
      7'b0010111: begin legal = 1'b1; c_w = 1'b1; imm_kind = IMM_U; end
      7'b1101111: begin legal = 1'b1; c_w = 1'b1; c_j = 1'b1; imm_kind = IMM_J; end
      7'b1100111: begin
        legal = (f3 == 3'b000); c_w = 1'b1; c_j = 1'b1; imm_kind = IMM_I;
      end
      7'b1100011: begin
        legal = (f3[2:1] != 2'b01); c_b = 1'b1; c_sign = !f3[1]; imm_kind = IMM_B;
      end
      7'b0000011: begin
        legal = (f3[1:0] != 2'b11) && !(f3[2] && f3[1]);
        c_l = 1'b1; c_w = 1'b1; c_sext = !f3[2]; c_dw = f3[1:0]; imm_kind = IMM_I;
      end
      7'b0100011: begin
        legal = !f3[2] && (f3[1:0] != 2'b11); c_s = 1'b1; c_dw = f3[1:0]; imm_kind = IMM_S;
      end
      7'b0010011: begin
        c_w = 1'b1; c_a = 1'b1; imm_kind = IMM_I;
        case (f3)
          3'b001:  legal = (f7 == 7'b0000000);
          3'b101:  begin
            legal  = (f7 == 7'b0000000) || (f7 == 7'b0100000);
            c_sign = f7[5];
          end
          3'b010:  begin legal = 1'b1; c_sign = 1'b1; end
          default: legal = 1'b1;
        endcase
      end
      7'b0110011: begin
        if (f7 == 7'b0000000) begin
          legal = 1'b1; c_w = 1'b1; c_a = 1'b1; c_sign = (f3 == 3'b010);
        end else if (f7 == 7'b0100000) begin
          legal = (f3 == 3'b000) || (f3 == 3'b101); c_w = 1'b1; c_a = 1'b1; c_sign = 1'b1;
        end else if (f7 == 7'b0000001) begin
          legal = EN_M; c_w = 1'b1; c_m = 1'b1;
        end
      end
      7'b0001111: legal = (f3 == 3'b000);
      7'b1110011: begin
        legal = (dec_instr == 32'h0000_0073) || (dec_instr == 32'h0010_0073); c_sys = 1'b1;
      end
      default: legal = 1'b0;
    endcase

    d_cs = '0; d_imm = '0; d_sel = 2'b00; d_ill = !legal;
    if (legal) begin
      // Writes to x0 are architecturally dead, so w drops; j still marks the jump.
      d_cs = {c_sys, c_dw, c_ign, c_sext, c_sign, c_m, c_a, c_j, c_b,
              c_w && (dec_instr[11:7] != 5'd0), c_l, c_s};
      case (imm_kind)
        IMM_I: begin
          d_imm = {{20{dec_instr[31]}}, dec_instr[31:20]}; d_sel = 2'b10;
        end
        IMM_S: begin
          d_imm = {{20{dec_instr[31]}}, dec_instr[31:25], dec_instr[11:7]}; d_sel = 2'b10;
        end
        IMM_B: d_imm = {{19{dec_instr[31]}}, dec_instr[31], dec_instr[7],
                        dec_instr[30:25], dec_instr[11:8], 1'b0};
        IMM_U: begin
          d_imm = {dec_instr[31:12], 12'h000}; d_sel = 2'b11;
        end
        IMM_J: begin
          d_imm = {{11{dec_instr[31]}}, dec_instr[31], dec_instr[19:12],
                   dec_instr[20], dec_instr[30:21], 1'b0};
          d_sel = 2'b11;
        end
        default: d_imm = '0;
      endcase
    end
  end

  // ---------------- buffer storage (no reset needed) ----------------
  always_ff @(posedge clk) begin
    if (enq && !rst) begin
      buf_instr[tail_reg] <= in_instr;
      buf_pc[tail_reg]    <= in_pc;
    end
  end

  // ---------------- pointers and output register ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      head_reg        <= '0;
      tail_reg        <= '0;
      count_reg       <= '0;
      out_valid_reg   <= 1'b0;
      out_pc          <= '0;
      out_rs1         <= '0;
      out_rs2         <= '0;
      out_rd          <= '0;
      out_func3       <= '0;
      out_imm         <= '0;
      out_alu_src_sel <= '0;
      out_cs          <= '0;
      out_illegal     <= 1'b0;
    end else if (flush) begin
      head_reg      <= '0;
      tail_reg      <= '0;
      count_reg     <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      if (enq) tail_reg <= next_ptr(tail_reg);
      if (deq) head_reg <= next_ptr(head_reg);
      if (enq && !deq)      count_reg <= count_reg + CNT_W'(1);
      else if (!enq && deq) count_reg <= count_reg - CNT_W'(1);
      if (out_load) begin
        out_valid_reg <= load_valid;
        if (load_valid) begin
          out_pc          <= dec_pc;
          out_rs1         <= dec_instr[19:15];
          out_rs2         <= dec_instr[24:20];
          out_rd          <= dec_instr[11:7];
          out_func3       <= f3;
          out_imm         <= d_imm;
          out_alu_src_sel <= d_sel;
          out_cs          <= d_cs;
          out_illegal     <= d_ill;
        end
      end
    end
  end

endmodule

// File: doc/ir_dec_stage.md
Name: ir_dec_stage

Overview:
- Next-generation RV32 decode stage that replaces the fixed stall/flush decode register with a valid/ready elastic stage.
- Parametrised instruction buffer in front of the decoder; registered decode output.
- Decodes RV32I, optionally RV32M, FENCE and ECALL/EBREAK; flags illegal encodings.
- Sits between fetch and execute.

Parameters:
- FIFO_DEPTH, 2: instruction buffer entries, >=1. Power of two not required.
- PC_WIDTH, 32: width of the PC carried alongside each instruction.
- EN_M, 1: 1 decodes RV32M; 0 makes every f7=0000001 OP encoding illegal.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  synchronous kill of buffered and output instructions
- in_valid  in  1  fetch offers an instruction
- in_ready  out  1  stage accepts an instruction
- in_instr  in  32  instruction word
- in_pc  in  PC_WIDTH  instruction PC
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  execute consumes the bundle
- out_pc  out  PC_WIDTH  PC of the bundle
- out_rs1, out_rs2, out_rd  out  5 each  instr[19:15], instr[24:20], instr[11:7]
- out_func3  out  3  instr[14:12]
- out_imm  out  32  immediate for the decoded type
- out_alu_src_sel  out  2  00 for R/B/none, 10 for I/S, 11 for U/J
- out_cs  out  13  control signals. Bit map: [0]s [1]l [2]w [3]b [4]j [5]a [6]m [7]sign [8]sign_ex [9]ignore_first_operand [11:10]dw (0=B, 1=H, 2=W) [12]sys
- out_illegal  out  1  bundle is an illegal encoding

Behaviour:
- Reset: all out_* = 0, buffer empty, out_valid = 0. in_ready = 0 during the reset cycle and 1 after.
- in_ready = (buffer count < FIFO_DEPTH). It is independent of in_valid; out_ready may feed in combinationally only through the count.
- Transfers: in accepts on in_valid&&in_ready; out consumes on out_valid&&out_ready.
- The output register loads when !out_valid or out_ready.
- Bypass: if the buffer is empty and the output register loads on the accepting edge, the incoming word is decoded straight into the output register. Latency is 1 cycle (out_valid high the cycle after acceptance).
- Otherwise the word enqueues. The buffer head is decoded and loaded whenever the output register loads.
- Order is strict FIFO. Simultaneous enqueue and dequeue on a full buffer is not allowed because in_ready is low.
- Throughput: 1 instruction per cycle with out_ready held high.
- Bundle stability: while out_valid && !out_ready, every out_* holds its value.
- flush (priority below rst): on the edge, the buffer empties and out_valid = 0. An instruction offered that cycle is dropped. out data fields may hold stale values. in_ready = 1 the next cycle.
- Immediates: I, S, B, U and J use standard RV32 sign-extended encodings; R has imm = 0.
- Decode table, by cs bits set:
  - LUI: w, ignore_first_operand (U).
  - AUIPC: w (U).
  - JAL: w, j (J).
  - JALR: w, j (I).
  - BEQ/BNE/BLT/BGE: b, sign (B).
  - BLTU/BGEU: b only (B).
  - LB/LH/LW: l, w, sign_ex, dw by size.
  - LBU/LHU: l, w, dw by size.
  - SB/SH/SW: s, dw by size (S).
  - OP-IMM: w, a; sign additionally for SLTI and SRAI. SLLI requires f7 = 0; SRLI/SRAI require f7 = 0000000/0100000.
  - OP: w, a; sign additionally for SUB, SLT and SRA.
  - M ops (all eight, including REMU f3 = 7): w, m.
  - FENCE: all cs = 0, legal.
  - ECALL (0x00000073) and EBREAK (0x00100073): sys only.
- Unsigned compares (SLTIU, SLTU, BLTU, BGEU) have sign = 0.
- w is forced to 0 when rd = 0; j and all other bits are unaffected.
- Illegal: any other encoding, including load/store with f3 not in the table and M ops with EN_M = 0. Result is out_illegal = 1, cs = 0, imm = 0, alu_src_sel = 00. The bundle is still delivered with out_valid.

Test Plan:
- After reset, push 0x00500093 (ADDI x1,x0,5), out_ready = 1 -> next cycle out_valid = 1, imm = 5, cs = w|a (0x024), alu_src_sel = 10, rd = 1.
- Push 0x12345137 (LUI x2) then 0x402081B3 (SUB x3,x1,x2) back-to-back -> consecutive bundles:
  - LUI: imm = 0x12345000, sel = 11, cs = 0x204.
  - SUB: cs = 0x0A4, imm = 0.
- EN_M = 0, push 0x027302B3 (MUL) -> out_illegal = 1, cs = 0. With EN_M = 1 -> cs = 0x044. Push 0xFFFFFFFF -> out_illegal = 1.
- FIFO_DEPTH = 2, out_ready = 0, offer 4 instructions -> 3 accepted (1 in output register, 2 in buffer) and in_ready low. Release out_ready -> outputs appear in the original order, one per cycle.
- With a full buffer and out_valid high, assert flush together with in_valid -> next cycle out_valid = 0, in_ready = 1, and no dropped instruction ever appears.
- Push 0x0000006F (JAL x0) -> j = 1, w = 0. Push 0x00100073 -> cs = 0x1000, out_illegal = 0.
